alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 8, datapath width in bits (legal 4..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 SHR, 7 ROR, 8 SAR, 9 SHL, 10 ROL, 11 MUL, 12 DIV, 13-15 illegal.
REQ-007 SHALL have ports: a, b  input  WIDTH each  operands; cy_i  input  1  carry/borrow in.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports: res_lo, res_hi  output  WIDTH each  result / MUL high half / DIV remainder.
REQ-011 SHALL have ports: cy_o, ac_o, ov_o  output  1 each  carry, auxiliary carry (bit 3), overflow.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL latch a, b, op, cy_i on in_valid && in_ready; inputs ignored in every other cycle.
REQ-014 SHALL move IDLE->DONE for ops 0-10, 13-15: out_valid asserted the cycle after acceptance (latency 1).
REQ-015 SHALL move IDLE->MUL for op 11: shift-add, one bit per cycle, WIDTH cycles, then DONE (latency WIDTH+1).
REQ-016 SHALL move IDLE->DIV for op 12 with b!=0: restoring division, one quotient bit per cycle, WIDTH cycles, then DONE (latency WIDTH+1).
REQ-017 SHALL stay in DONE with res_*, flags stable until out_ready=1, then go IDLE next cycle; no new request accepted in the DONE cycle.
REQ-018 ADD: res_lo = a+b+cy_i mod 2^WIDTH; cy_o = carry out of MSB; ac_o = carry out of bit 3; ov_o = signed overflow; res_hi = 0.
REQ-019 SUB: res_lo = a-b-cy_i mod 2^WIDTH; cy_o = borrow out of MSB; ac_o = borrow out of bit 3; ov_o = signed overflow.
REQ-020 AND/OR/XOR/NOT(~a): cy_o = cy_i, ac_o = 0, ov_o = 0.
REQ-021 Shifts by one on a: SHR fill 0, ROR, SAR fill a[MSB], SHL fill 0, ROL; cy_o = bit shifted out; ac_o = ov_o = 0.
REQ-022 MUL: {res_hi,res_lo} = a*b unsigned; cy_o = 0; ov_o = (res_hi!=0); ac_o = 0.
REQ-023 DIV: res_lo = a/b, res_hi = a%b unsigned; cy_o = 0; ov_o = 0.
REQ-024 DIV with b==0: latency 1, res_lo = all ones, res_hi = a, ov_o = 1, cy_o = 0.
REQ-025 Illegal op: latency 1, res_lo = res_hi = 0, ov_o = 1, cy_o = ac_o = 0.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, res_lo=res_hi=0, cy_o=ac_o=ov_o=0, iteration counter 0.
REQ-027 Reset during MUL/DIV/DONE SHALL abort the operation; no result is ever presented for it.

Configuration
REQ-028 Macro ALU_MC_DIV_EN defined: DIV state and iterative divider present per REQ-016/023/024.
REQ-029 ALU_MC_DIV_EN undefined: no DIV state or divider logic; op 12 treated exactly as an illegal op (REQ-025).

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01 cy_i=0 -> next cycle out_valid, res_lo=0x80, cy_o=0, ac_o=1, ov_o=1.
REQ-031 SUB a=0x00 b=0x01 cy_i=0 -> res_lo=0xFF, cy_o=1, ac_o=1, ov_o=0; ROL a=0x81 -> res_lo=0x03, cy_o=1.
REQ-032 MUL a=0x80 b=0x02 -> out_valid 9 cycles after acceptance, res_hi=0x01, res_lo=0x00, ov_o=1.
REQ-033 DIV a=0xFB b=0x12 -> 9 cycles, res_lo=0x0D, res_hi=0x11, ov_o=0; DIV b=0x00 a=0x5A -> 1 cycle, res_lo=0xFF, res_hi=0x5A, ov_o=1 (macro undefined: res 0/0, ov_o=1).
REQ-034 out_ready held 0 for 5 cycles after out_valid -> outputs unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low 4 cycles into MUL -> out_valid=0, all outputs 0, next accepted ADD 0x01+0x01 returns 0x02 at latency 1.

Source files
------------

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Purpose  : Request/response bundle between an ALU client and alu_mc.
//            The request side is a valid/ready pair carrying opcode, operands
//            and carry-in. The response side is a valid/ready pair carrying
//            the low/high result words and the carry, auxiliary-carry and
//            overflow flags.
// Modports : master - client side (drives request, consumes result)
//            slave  - ALU side    (consumes request, drives result)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             cy_o;
  logic             ac_o;
  logic             ov_o;

  modport master (
    output in_valid, op, a, b, cy_i, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, cy_o, ac_o, ov_o
  );

  modport slave (
    input  in_valid, op, a, b, cy_i, out_ready,
    output in_ready, out_valid, res_lo, res_hi, cy_o, ac_o, ov_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU. Single-cycle ops (add/sub/logic/shift/rotate)
//            complete with latency 1; MUL is a shift-add multiplier and DIV a
//            restoring divider, each retiring one bit per cycle (latency
//            WIDTH+1). Results are held until the consumer takes them.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - alu_mc_if.slave (in_valid/in_ready/op/a/b/cy_i,
//                    out_valid/out_ready/res_lo/res_hi/cy_o/ac_o/ov_o)
// Config   : ALU_MC_DIV_EN - when defined, op 12 (DIV) and the iterative
//            divider are built; otherwise op 12 is treated as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus
);
  localparam int         MSB    = WIDTH - 1;
  localparam int         CW     = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_MUL = 4'd11;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd12;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  // Shared iteration registers: acc_hi = partial product / remainder,
  // acc_lo = multiplier / dividend-quotient, opnd = multiplicand / divisor.
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             cy_q, ac_q, ov_q;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.cy_o      = cy_q;
  assign bus.ac_o      = ac_q;
  assign bus.ov_o      = ov_q;

  // ---------------- single-cycle result, computed from live inputs ----------
  logic [WIDTH:0]   add_full, sub_full;
  logic [4:0]       add_nib, sub_nib;
  logic [WIDTH-1:0] one_lo, one_hi;
  logic             one_cy, one_ac, one_ov;

  always_comb begin
    add_full = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cy_i};
    sub_full = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cy_i};
    add_nib  = {1'b0, bus.a[3:0]} + {1'b0, bus.b[3:0]} + {4'b0, bus.cy_i};
    sub_nib  = {1'b0, bus.a[3:0]} - {1'b0, bus.b[3:0]} - {4'b0, bus.cy_i};
    one_lo   = '0;
    one_hi   = '0;
    one_cy   = 1'b0;
    one_ac   = 1'b0;
    one_ov   = 1'b0;
    case (bus.op)
      4'd0: begin
        one_lo = add_full[MSB:0];
        one_cy = add_full[WIDTH];
        one_ac = add_nib[4];
        one_ov = (bus.a[MSB] == bus.b[MSB]) && (add_full[MSB] != bus.a[MSB]);
      end
      4'd1: begin
        // Bit WIDTH / bit 4 of the widened difference is the borrow.
        one_lo = sub_full[MSB:0];
        one_cy = sub_full[WIDTH];
        one_ac = sub_nib[4];
        one_ov = (bus.a[MSB] != bus.b[MSB]) && (sub_full[MSB] != bus.a[MSB]);
      end
      4'd2:  begin one_lo = bus.a & bus.b; one_cy = bus.cy_i; end
      4'd3:  begin one_lo = bus.a | bus.b; one_cy = bus.cy_i; end
      4'd4:  begin one_lo = ~bus.a;        one_cy = bus.cy_i; end
      4'd5:  begin one_lo = bus.a ^ bus.b; one_cy = bus.cy_i; end
      4'd6:  begin one_lo = {1'b0, bus.a[MSB:1]};       one_cy = bus.a[0];   end
      4'd7:  begin one_lo = {bus.a[0], bus.a[MSB:1]};   one_cy = bus.a[0];   end
      4'd8:  begin one_lo = {bus.a[MSB], bus.a[MSB:1]}; one_cy = bus.a[0];   end
      4'd9:  begin one_lo = {bus.a[MSB-1:0], 1'b0};     one_cy = bus.a[MSB]; end
      4'd10: begin one_lo = {bus.a[MSB-1:0], bus.a[MSB]}; one_cy = bus.a[MSB]; end
`ifdef ALU_MC_DIV_EN
      // Only reached as a single-cycle result when b == 0.
      OP_DIV: begin one_lo = '1; one_hi = bus.a; one_ov = 1'b1; end
`endif
      default: one_ov = 1'b1;
    endcase
  end

  // ---------------- one iteration of the shift-add multiplier ---------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[MSB:1]};
  end

`ifdef ALU_MC_DIV_EN
  // ---------------- one iteration of the restoring divider ------------------
  // Shifted remainder is < 2*divisor, so bit WIDTH of the trial difference is
  // set exactly when the subtraction would go negative.
  logic [WIDTH:0]   div_try;
  logic [WIDTH-1:0] div_rem_nx, div_q_nx;

  always_comb begin
    div_try = {acc_hi, acc_lo[MSB]} - {1'b0, opnd};
    if (!div_try[WIDTH]) begin
      div_rem_nx = div_try[MSB:0];
      div_q_nx   = {acc_lo[MSB-1:0], 1'b1};
    end else begin
      div_rem_nx = {acc_hi[MSB-1:0], acc_lo[MSB]};
      div_q_nx   = {acc_lo[MSB-1:0], 1'b0};
    end
  end
`endif

  // ---------------- control FSM and registered outputs ---------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      cy_q     <= 1'b0;
      ac_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cnt <= '0;
            if (bus.op == OP_MUL) begin
              acc_hi <= '0;
              acc_lo <= bus.b;
              opnd   <= bus.a;
              state  <= S_MUL;
            end
`ifdef ALU_MC_DIV_EN
            else if (bus.op == OP_DIV && bus.b != '0) begin
              acc_hi <= '0;
              acc_lo <= bus.a;
              opnd   <= bus.b;
              state  <= S_DIV;
            end
`endif
            else begin
              res_lo_q <= one_lo;
              res_hi_q <= one_hi;
              cy_q     <= one_cy;
              ac_q     <= one_ac;
              ov_q     <= one_ov;
              state    <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MSB)) begin
            res_lo_q <= mul_lo_nx;
            res_hi_q <= mul_hi_nx;
            cy_q     <= 1'b0;
            ac_q     <= 1'b0;
            ov_q     <= (mul_hi_nx != '0);
            state    <= S_DONE;
          end
        end
`ifdef ALU_MC_DIV_EN
        S_DIV: begin
          acc_hi <= div_rem_nx;
          acc_lo <= div_q_nx;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MSB)) begin
            res_lo_q <= div_q_nx;
            res_hi_q <= div_rem_nx;
            cy_q     <= 1'b0;
            ac_q     <= 1'b0;
            ov_q     <= 1'b0;
            state    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=8): directed cases,
//            output-hold / back-pressure, reset abort, then random ops scored
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  alu_mc_if #(.WIDTH(8)) bus ();
  alu_mc #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented op rules.
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cy, output logic [7:0] lo, output logic [7:0] hi,
                       output logic ecy, output logic eac, output logic eov, output int lat);
    int ia, ib, ic, r, sa, sb, sr;
    ia = int'(a); ib = int'(b); ic = cy ? 1 : 0;
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    lo = 8'h00; hi = 8'h00; ecy = 1'b0; eac = 1'b0; eov = 1'b0; lat = 1;
    case (op)
      4'd0: begin
        r = ia + ib + ic; lo = 8'(r); ecy = (r > 255);
        eac = ((ia % 16) + (ib % 16) + ic) > 15;
        sr = sa + sb + ic; eov = (sr > 127) || (sr < -128);
      end
      4'd1: begin
        r = ia - ib - ic; lo = 8'(r); ecy = (r < 0);
        eac = ((ia % 16) - (ib % 16) - ic) < 0;
        sr = sa - sb - ic; eov = (sr > 127) || (sr < -128);
      end
      4'd2:  begin lo = a & b; ecy = cy; end
      4'd3:  begin lo = a | b; ecy = cy; end
      4'd4:  begin lo = ~a;    ecy = cy; end
      4'd5:  begin lo = a ^ b; ecy = cy; end
      4'd6:  begin lo = 8'(ia / 2);                  ecy = (ia % 2) == 1; end
      4'd7:  begin lo = 8'(ia / 2 + (ia % 2) * 128); ecy = (ia % 2) == 1; end
      4'd8:  begin lo = 8'(sa >>> 1);                ecy = (ia % 2) == 1; end
      4'd9:  begin lo = 8'(ia * 2);                  ecy = (ia > 127);    end
      4'd10: begin lo = 8'(ia * 2 + ia / 128);       ecy = (ia > 127);    end
      4'd11: begin
        r = ia * ib; lo = 8'(r); hi = 8'(r / 256); eov = (r > 255); lat = 9;
      end
`ifdef ALU_MC_DIV_EN
      4'd12: begin
        if (ib == 0) begin lo = 8'hFF; hi = a; eov = 1'b1; end
        else begin lo = 8'(ia / ib); hi = 8'(ia % ib); lat = 9; end
      end
`endif
      default: eov = 1'b1;
    endcase
  endtask

  // Issue one request, measure latency, check result, optionally stall the
  // consumer for 'hold' cycles while poking in_valid, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cy, input int hold);
    logic [7:0] elo, ehi;
    logic       ecy, eac, eov;
    int         elat, lat;
    model(op, a, b, cy, elo, ehi, ecy, eac, eov, elat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cy_i = cy;
    bus.out_ready = 1'b0;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    // Garbage request kept pending: must be ignored while busy.
    bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    bus.cy_i = 1'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".res_lo"}, 32'(bus.res_lo), 32'(elo));
    check({tag, ".res_hi"}, 32'(bus.res_hi), 32'(ehi));
    check({tag, ".flags"}, 32'({bus.cy_o, bus.ac_o, bus.ov_o}), 32'({ecy, eac, eov}));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom); bus.op = 4'($urandom); bus.a = 8'($urandom);
      @(posedge clk); #1;
      check({tag, ".hold_ctl"}, 32'({bus.in_ready, bus.out_valid}), 32'b01);
      check({tag, ".hold_res"}, 32'({bus.res_lo, bus.res_hi, bus.cy_o, bus.ac_o, bus.ov_o}),
            32'({elo, ehi, ecy, eac, eov}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".drain"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  initial begin
    int seen;
    logic [3:0] rop;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00; bus.cy_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.ctl", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("reset.res", 32'({bus.res_lo, bus.res_hi, bus.cy_o, bus.ac_o, bus.ov_o}), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op("add_7f_01", 4'd0, 8'h7F, 8'h01, 1'b0, 0);
    run_op("sub_00_01", 4'd1, 8'h00, 8'h01, 1'b0, 0);
    run_op("rol_81",    4'd10, 8'h81, 8'h00, 1'b0, 0);
    run_op("sar_90",    4'd8, 8'h90, 8'h00, 1'b0, 0);
    run_op("mul_80_02", 4'd11, 8'h80, 8'h02, 1'b0, 0);
    run_op("mul_ff_ff", 4'd11, 8'hFF, 8'hFF, 1'b0, 0);
    run_op("div_fb_12", 4'd12, 8'hFB, 8'h12, 1'b0, 0);
    run_op("div_5a_00", 4'd12, 8'h5A, 8'h00, 1'b0, 0);
    run_op("illegal_13", 4'd13, 8'h12, 8'h34, 1'b1, 0);
    run_op("hold_add",  4'd0, 8'h3C, 8'h4D, 1'b1, 5);

    // Reset four cycles into a multiply aborts it
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd11; bus.a = 8'hC3; bus.b = 8'h5F;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mul.ctl", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("rst_mul.res", 32'({bus.res_lo, bus.res_hi, bus.cy_o, bus.ac_o, bus.ov_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("rst_mul.no_result", 32'(seen), 32'd0);
    run_op("rst_add_01_01", 4'd0, 8'h01, 8'h01, 1'b0, 0);

    // Random operations against the reference model
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
